// File: rtl/fx3_stream_in_tx.sv
// FX3 stream-in producer: FIFO-buffers 32-bit words, offers BURST_LEN-word bursts; optional FX3_TX_TEST_PATTERN_EN stores a counter.
// Latency: fx3_read_ready sampled -> data registered on the same edge (1 cycle); arm 1 cycle after count reaches BURST_LEN.
// Backpressure: none on s_valid; a word arriving at a full FIFO without a pop is dropped and overflow sticks.
module fx3_stream_in_tx #(
    parameter int FIFO_DEPTH = 8192,
    parameter int BURST_LEN  = 4096
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        fx3_resetn,
    input  logic [31:0] s_data,
    input  logic        s_valid,
    input  logic        fx3_read_ready,
    output logic [31:0] data,
    output logic        fx3_data_available,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, ARMED, STREAM} state_t;

    state_t        state_q, state_d;
    logic [31:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [CW-1:0] count_q, count_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [31:0]   data_q;
    logic          ovf_q;
    logic          pop, full, push_ok, drop;
    logic [31:0]   wr_word;

`ifdef FX3_TX_TEST_PATTERN_EN
    // Advances on every s_valid, dropped words included, so gaps show up downstream.
    logic [31:0] pat_q;
    logic        unused_s_data;
    assign unused_s_data = ^s_data;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn)         pat_q <= '0;
        else if (!fx3_resetn) pat_q <= '0;
        else if (s_valid)     pat_q <= pat_q + 32'd1;
    end
    assign wr_word = pat_q;
`else
    assign wr_word = s_data;
`endif

    assign pop     = fx3_read_ready && (state_q == ARMED || state_q == STREAM);
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign push_ok = s_valid && (!full || pop);
    assign drop    = s_valid && full && !pop;

    always_comb begin
        count_d = count_q;
        if (push_ok && !pop)      count_d = count_q + CW'(1);
        else if (!push_ok && pop) count_d = count_q - CW'(1);
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else if (!fx3_resetn) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
        end
    end

    // The ARMED cycle that sees read_ready already performs pop number one.
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        case (state_q)
            IDLE: begin
                if (count_q >= CW'(BURST_LEN)) state_d = ARMED;
            end
            ARMED: begin
                if (fx3_read_ready) begin
                    state_d = STREAM;
                    beat_d  = BW'(1);
                end
            end
            STREAM: begin
                if (fx3_read_ready) begin
                    if (beat_q == BW'(BURST_LEN - 1)) begin
                        state_d = IDLE;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        fx3_data_available = (state_q == ARMED);
        data               = data_q;
        overflow           = ovf_q;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else if (!fx3_resetn) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            if (push_ok) wptr_q <= wptr_q + AW'(1);
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
                data_q <= mem_q[rptr_q];
            end
            if (drop) ovf_q <= 1'b1;
        end
    end

    // Storage has no reset; the pointers define what is valid.
    always_ff @(posedge aclk) begin
        if (push_ok) mem_q[wptr_q] <= wr_word;
    end

endmodule

// File: tb/tb_fx3_stream_in_tx.sv
// Directed bench for fx3_stream_in_tx: small FIFO instance plus one default-size instance.
module tb_fx3_stream_in_tx;
    localparam int DEPTH = 16;
    localparam int BL    = 8;
    localparam int DBL   = 4096;

    logic        aclk = 1'b0;
    always #5 aclk = ~aclk;

    logic        aresetn, fx3_resetn, s_valid, rr;
    logic [31:0] s_data, data;
    logic        avail, ovf;
    logic        d_valid, d_rr;
    logic [31:0] d_sdata, d_data;
    logic        d_avail, d_ovf;

    fx3_stream_in_tx #(.FIFO_DEPTH(DEPTH), .BURST_LEN(BL)) dut (
        .aclk(aclk), .aresetn(aresetn), .fx3_resetn(fx3_resetn),
        .s_data(s_data), .s_valid(s_valid), .fx3_read_ready(rr),
        .data(data), .fx3_data_available(avail), .overflow(ovf)
    );

    fx3_stream_in_tx dut_def (
        .aclk(aclk), .aresetn(aresetn), .fx3_resetn(fx3_resetn),
        .s_data(d_sdata), .s_valid(d_valid), .fx3_read_ready(d_rr),
        .data(d_data), .fx3_data_available(d_avail), .overflow(d_ovf)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] sb[$];
    logic [31:0] pat_m    = 32'd0;
    logic [31:0] last_exp = 32'd0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_word(input logic [31:0] d, input logic [31:0] p);
`ifdef FX3_TX_TEST_PATTERN_EN
        return p;
`else
        return d;
`endif
    endfunction

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    task automatic push(input logic [31:0] d);
        s_valid = 1'b1;
        s_data  = d;
        if (sb.size() < DEPTH) sb.push_back(exp_word(d, pat_m));
        pat_m = pat_m + 32'd1;
        tick();
        s_valid = 1'b0;
    endtask

    task automatic push_n(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) push(base + 32'(i));
    endtask

    task automatic read_n(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            rr = 1'b1;
            tick();
            last_exp = sb.pop_front();
            check(tag, data, last_exp);
        end
        rr = 1'b0;
    endtask

    task automatic wait_avail(input string tag);
        int k = 0;
        while (avail !== 1'b1 && k < 40) begin
            tick();
            k++;
        end
        check(tag, 32'(avail), 32'd1);
    endtask

    task automatic clear_model();
        sb.delete();
        pat_m = 32'd0;
    endtask

    initial begin
        aresetn = 1'b0; fx3_resetn = 1'b1; s_valid = 1'b0; rr = 1'b0; s_data = '0;
        d_valid = 1'b0; d_rr = 1'b0; d_sdata = '0;
        #12;
        check("rst_data", data, 32'd0);
        check("rst_avail", 32'(avail), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        tick();
        aresetn = 1'b1;
        tick();

        // Arming threshold
        push_n(7, 32'hA0);
        tick(); tick();
        check("seven_no_avail", 32'(avail), 32'd0);
        push(32'hA7);
        tick();
        check("eighth_arms", 32'(avail), 32'd1);
        read_n(8, "burst_a");
        check("a_idle_avail", 32'(avail), 32'd0);

        // read_ready in IDLE is ignored
        rr = 1'b1;
        tick(); tick();
        rr = 1'b0;
        check("idle_rr_hold", data, last_exp);

        // Mid-burst pause
        push_n(8, 32'hB0);
        wait_avail("b_arm");
        read_n(4, "burst_b_lo");
        for (int i = 0; i < 3; i++) begin
            tick();
            check("pause_hold", data, last_exp);
            check("pause_avail", 32'(avail), 32'd0);
        end
        read_n(4, "burst_b_hi");
        check("b_idle_avail", 32'(avail), 32'd0);

        // Full FIFO with simultaneous push and pop
        push_n(16, 32'hC0);
        check("full_no_ovf", 32'(ovf), 32'd0);
        wait_avail("c_arm");
        s_valid = 1'b1; s_data = 32'hD0; rr = 1'b1;
        last_exp = sb.pop_front();
        sb.push_back(exp_word(32'hD0, pat_m));
        pat_m = pat_m + 32'd1;
        tick();
        s_valid = 1'b0;
        check("full_pop_data", data, last_exp);
        check("full_pop_no_ovf", 32'(ovf), 32'd0);
        read_n(7, "burst_c_lo");
        check("b2b_gap_low", 32'(avail), 32'd0);
        tick();
        check("b2b_rearm", 32'(avail), 32'd1);
        read_n(8, "burst_c_hi");

        // Overflow: 1 left + 15 fills, next word dropped
        push_n(15, 32'hE0);
        check("pre_ovf", 32'(ovf), 32'd0);
        push(32'hEF);
        check("ovf_set", 32'(ovf), 32'd1);
        wait_avail("e_arm");
        read_n(8, "burst_e_lo");
        check("ovf_sticky1", 32'(ovf), 32'd1);
        wait_avail("e_arm2");
        read_n(8, "burst_e_hi");
        check("ovf_sticky2", 32'(ovf), 32'd1);
        check("e_idle_avail", 32'(avail), 32'd0);

        // Synchronous link reset with a burst pending
        push_n(8, 32'h50);
        wait_avail("h_arm");
        fx3_resetn = 1'b0;
        tick();
        fx3_resetn = 1'b1;
        clear_model();
        check("frst_data", data, 32'd0);
        check("frst_avail", 32'(avail), 32'd0);
        check("frst_ovf", 32'(ovf), 32'd0);

        // Async reset during pop 5
        push_n(8, 32'hF0);
        wait_avail("f_arm");
        read_n(4, "burst_f");
        rr = 1'b1;
        #3;
        aresetn = 1'b0;
        #1;
        check("arst_data", data, 32'd0);
        check("arst_avail", 32'(avail), 32'd0);
        check("arst_ovf", 32'(ovf), 32'd0);
        clear_model();
        tick(); tick();
        rr = 1'b0;
        aresetn = 1'b1;
        tick();
        push_n(7, 32'h60);
        tick();
        check("post_rst_no_avail", 32'(avail), 32'd0);
        push(32'h67);
        wait_avail("post_rst_arm");
        read_n(8, "burst_g");

        // Default-size instance: one full burst
        for (int i = 0; i < DBL - 1; i++) begin
            d_valid = 1'b1;
            d_sdata = 32'h1000_0000 + 32'(i);
            tick();
        end
        d_valid = 1'b0;
        tick(); tick();
        check("def_no_avail", 32'(d_avail), 32'd0);
        d_valid = 1'b1;
        d_sdata = 32'h1000_0000 + 32'(DBL - 1);
        tick();
        d_valid = 1'b0;
        tick();
        check("def_arm", 32'(d_avail), 32'd1);
        for (int i = 0; i < DBL; i++) begin
            d_rr = 1'b1;
            tick();
            check("def_burst", d_data, exp_word(32'h1000_0000 + 32'(i), 32'(i)));
        end
        d_rr = 1'b0;
        check("def_idle", 32'(d_avail), 32'd0);
        check("def_ovf", 32'(d_ovf), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
